c4e_i2c_master: RTL and testbench
=================================

C4E_I2C_MASTER -- requirements
Module: c4e_i2c_master

Interface
REQ-001 Parameter DIV_DEFAULT, default 16'd124, reset value of the quarter-bit divider.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 address  input  2  Avalon-MM slave word address.
REQ-005 chipselect  input  1  slave select.
REQ-006 write_n  input  1  active-low write strobe, valid with chipselect.
REQ-007 writedata  input  32  write data.
REQ-008 readdata  output  32  registered read data.
REQ-009 irq  output  1  completion interrupt.
REQ-010 scl_oe / sda_oe  output  1 each  1 = drive pin low, 0 = release (open drain).
REQ-011 scl_in / sda_in  input  1 each  sampled pin levels, already synchronized.

Function
REQ-012 A write SHALL occur on any clk edge with chipselect=1 and write_n=0; there is no wait state.
REQ-013 readdata SHALL update every cycle to the mux of address, for one cycle of read latency; unused bits read 0.
REQ-014 Addr 0 DATA: write loads txbyte=writedata[7:0]; read returns rxbyte.
REQ-015 Addr 1 CMD write bits: [0] START, [1] WR, [2] RD, [3] STOP, [4] ACKVAL (bit sent after RD), [5] IEN.
REQ-016 Addr 1 STATUS read bits: [0] busy, [1] rx_nack, [2] done, [5] IEN.
REQ-017 Addr 2 DIV: write loads div=writedata[15:0]; read returns div.
REQ-018 Addr 3 SHALL be reserved: writes are ignored and reads return 0.
REQ-019 Writes to DATA, DIV or CMD while busy=1 SHALL be ignored entirely, including IEN.
REQ-020 A CMD write while idle SHALL:
- update IEN;
- clear done;
- set busy=1 on the next cycle if any of START/WR/RD/STOP is set; otherwise it is a no-op.
REQ-021 WR and RD both set SHALL execute as WR only.
REQ-022 The sequencer SHALL run the phases START, then BYTE (WR or RD), then STOP, skipping any phase whose bit is clear.
REQ-023 The quarter-bit tick SHALL fire every div+1 clk cycles; div=0 gives a tick every cycle.
REQ-024 Every phase SHALL consist of 4 quarters q0..q3, and each quarter SHALL last one tick.
REQ-025 START quarters (scl, sda released=1): q0 1,1; q1 1,1; q2 1,0; q3 0,0.
REQ-026 BYTE SHALL transfer 9 bits, MSB first; bits 0-7 are data and bit 8 is ACK.
REQ-027 Per bit: q0 scl=0 with sda set; q1 scl=1; q2 scl=1; q3 scl=0.
REQ-028 WR SHALL drive txbyte bits, release sda on the ACK bit, and sample sda_in into rx_nack.
REQ-029 RD SHALL release sda on the data bits, shift sda_in into rxbyte, and drive ACKVAL on the ACK bit (0 = ACK).
REQ-030 sda_in SHALL be sampled on the tick that ends q1.
REQ-031 Clock stretching: in q1 and q2 with scl released, the tick counter SHALL hold while scl_in=0 and resume when scl_in=1.
REQ-032 STOP quarters (scl, sda): q0 0,0; q1 1,0; q2 1,0; q3 1,1.
REQ-033 On completion of the last phase, busy SHALL clear and done SHALL set in the same cycle.
REQ-034 Without STOP, scl SHALL stay low and sda SHALL hold its last value until the next command.
REQ-035 irq SHALL equal done AND IEN, as a registered output.

Reset
REQ-036 Reset SHALL set: busy=0, done=0, rx_nack=0, IEN=0, rxbyte=0, txbyte=0, div=DIV_DEFAULT, scl_oe=0, sda_oe=0, readdata=0, irq=0.
REQ-037 Reset asserted mid-transfer SHALL abort in one cycle to the reset state and generate no STOP.

Verification
REQ-038 div=4; DATA=0xA5; CMD=0x0B -> busy for exactly 220 cycles; sda bits 1,0,1,0,0,1,0,1 at scl rises; slave ACK -> rx_nack=0, done=1.
REQ-039 div=0; CMD=0x02 with slave releasing sda on ACK -> rx_nack=1 after 36 cycles; scl_oe stays 1 afterward.
REQ-040 div=1; slave sends 0x3C; CMD=0x3C (RD, STOP, ACKVAL=1, IEN) -> DATA reads 0x3C; sda released on the 9th bit; irq=1 until the next CMD write.
REQ-041 Hold scl_in=0 for 50 cycles during bit 3 q1 -> busy duration extended by exactly 50 cycles; no bit is lost.
REQ-042 While busy, write DIV=7 and DATA=0xFF -> both reads return their old values; assert reset mid-byte -> next cycle scl_oe=sda_oe=0, busy=0, div=124.

Source files
------------

// File: rtl/c4e_i2c_master.sv
// Avalon-MM I2C master: byte-oriented START / WR|RD / STOP sequencer with a
// quarter-bit tick, clock stretching and a registered completion interrupt.
module c4e_i2c_master #(
    parameter logic [15:0] DIV_DEFAULT = 16'd124
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        scl_in,
    input  logic        sda_in
);

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_START,
        PH_BYTE,
        PH_STOP
    } phase_e;

    phase_e      phase_q, phase_d;
    logic [1:0]  quarter_q, quarter_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  txbyte_q, txbyte_d;
    logic [7:0]  rxbyte_q, rxbyte_d;
    logic        rx_nack_q, rx_nack_d;
    logic        done_q, done_d;
    logic        ien_q, ien_d;
    logic        do_byte_q, do_byte_d;
    logic        do_stop_q, do_stop_d;
    logic        is_rd_q, is_rd_d;
    logic        ackval_q, ackval_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_oe_q, sda_oe_d;
    logic [31:0] readdata_q, readdata_d;
    logic        irq_q, irq_d;

    logic busy, wr_en, hold, tick, bit_val, scl_rel, sda_rel;
    logic unused_wdata;

    assign busy         = (phase_q != PH_IDLE);
    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata[31:16];

    // NOTE: every _d gets its current value first so no path leaves it unassigned (no latches).
    always_comb begin
        phase_d    = phase_q;
        quarter_d  = quarter_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        txbyte_d   = txbyte_q;
        rxbyte_d   = rxbyte_q;
        rx_nack_d  = rx_nack_q;
        done_d     = done_q;
        ien_d      = ien_q;
        do_byte_d  = do_byte_q;
        do_stop_d  = do_stop_q;
        is_rd_d    = is_rd_q;
        ackval_d   = ackval_q;
        scl_oe_d   = scl_oe_q;
        sda_oe_d   = sda_oe_q;
        readdata_d = 32'd0;
        bit_val    = 1'b1;
        scl_rel    = 1'b1;
        sda_rel    = 1'b1;

        // A slave holding scl low while we release it freezes the quarter timer.
        hold = busy && (quarter_q == 2'd1 || quarter_q == 2'd2) && !scl_oe_q && !scl_in;
        tick = busy && !hold && (cnt_q == div_q);

        if (busy && !hold) begin
            cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        end

        if (tick) begin
            if (phase_q == PH_BYTE && quarter_q == 2'd1) begin
                if (bit_q == 4'd8) begin
                    if (!is_rd_q) rx_nack_d = sda_in;
                end else if (is_rd_q) begin
                    rxbyte_d = {rxbyte_q[6:0], sda_in};
                end
            end
            if (quarter_q != 2'd3) begin
                quarter_d = quarter_q + 2'd1;
            end else begin
                quarter_d = 2'd0;
                if (phase_q == PH_BYTE && bit_q != 4'd8) begin
                    bit_d = bit_q + 4'd1;
                end else if (phase_q == PH_START && do_byte_q) begin
                    phase_d = PH_BYTE;
                    bit_d   = 4'd0;
                end else if (phase_q != PH_STOP && do_stop_q) begin
                    phase_d = PH_STOP;
                end else begin
                    phase_d = PH_IDLE;
                    done_d  = 1'b1;
                end
            end
        end

        if (!busy && wr_en) begin
            case (address)
                2'd0: txbyte_d = writedata[7:0];
                2'd1: begin
                    ien_d  = writedata[5];
                    done_d = 1'b0;
                    if (|writedata[3:0]) begin
                        do_byte_d = writedata[1] | writedata[2];
                        is_rd_d   = writedata[2] & ~writedata[1];
                        do_stop_d = writedata[3];
                        ackval_d  = writedata[4];
                        cnt_d     = 16'd0;
                        quarter_d = 2'd0;
                        bit_d     = 4'd0;
                        if (writedata[0])                     phase_d = PH_START;
                        else if (writedata[1] | writedata[2]) phase_d = PH_BYTE;
                        else                                  phase_d = PH_STOP;
                    end
                end
                2'd2: div_d = writedata[15:0];
                default: ;
            endcase
        end

        // Pin drive for the quarter that starts next, so outputs line up with state.
        if (bit_d == 4'd8) bit_val = is_rd_d ? ackval_d : 1'b1;
        else               bit_val = is_rd_d ? 1'b1 : txbyte_d[3'd7 - bit_d[2:0]];

        case (phase_d)
            PH_START: begin
                scl_rel = (quarter_d != 2'd3);
                sda_rel = (quarter_d < 2'd2);
            end
            PH_BYTE: begin
                scl_rel = (quarter_d == 2'd1) || (quarter_d == 2'd2);
                sda_rel = bit_val;
            end
            PH_STOP: begin
                scl_rel = (quarter_d != 2'd0);
                sda_rel = (quarter_d == 2'd3);
            end
            default: begin
                scl_rel = ~scl_oe_q;
                sda_rel = ~sda_oe_q;
            end
        endcase
        scl_oe_d = ~scl_rel;
        sda_oe_d = ~sda_rel;

        case (address)
            2'd0: readdata_d = {24'd0, rxbyte_q};
            2'd1: readdata_d = {26'd0, ien_q, 2'b00, done_q, rx_nack_q, busy};
            2'd2: readdata_d = {16'd0, div_q};
            default: readdata_d = 32'd0;
        endcase

        irq_d = done_d & ien_d;
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= PH_IDLE;
            quarter_q  <= 2'd0;
            bit_q      <= 4'd0;
            cnt_q      <= 16'd0;
            div_q      <= DIV_DEFAULT;
            txbyte_q   <= 8'd0;
            rxbyte_q   <= 8'd0;
            rx_nack_q  <= 1'b0;
            done_q     <= 1'b0;
            ien_q      <= 1'b0;
            do_byte_q  <= 1'b0;
            do_stop_q  <= 1'b0;
            is_rd_q    <= 1'b0;
            ackval_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            quarter_q  <= quarter_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            txbyte_q   <= txbyte_d;
            rxbyte_q   <= rxbyte_d;
            rx_nack_q  <= rx_nack_d;
            done_q     <= done_d;
            ien_q      <= ien_d;
            do_byte_q  <= do_byte_d;
            do_stop_q  <= do_stop_d;
            is_rd_q    <= is_rd_d;
            ackval_q   <= ackval_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;

endmodule

// File: tb/tb_c4e_i2c_master.sv
// Bench for c4e_i2c_master: register vectors, then write/read/stretch/reset
// sequences against a small open-drain slave model.
module tb_c4e_i2c_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        scl_oe;
    logic        sda_oe;
    logic        scl_in;
    logic        sda_in;

    logic        stretch    = 1'b0;
    logic        slave_low  = 1'b0;
    logic        slave_rd   = 1'b0;
    logic        slave_ack  = 1'b0;
    logic [7:0]  slave_byte = 8'h00;
    logic [7:0]  cap_byte   = 8'h00;
    logic        ack_seen   = 1'b0;
    logic        scl_prev   = 1'b1;
    int          bitcnt     = 100;
    int          arm_req    = 0;
    int          arm_seen   = 0;

    int checks = 0;
    int errors = 0;

    assign scl_in = ~scl_oe & ~stretch;
    assign sda_in = ~sda_oe & ~slave_low;

    always #5 clk = ~clk;

    c4e_i2c_master dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .scl_in     (scl_in),
        .sda_in     (sda_in)
    );

    // Slave: counts scl falls once armed, captures sda on scl rises, and
    // either ACKs a written byte or shifts out slave_byte for a read.
    always @(negedge clk) begin
        if (arm_req != arm_seen) begin
            bitcnt   = -1;
            arm_seen = arm_req;
        end
        if (!scl_prev && scl_in && bitcnt >= 0 && bitcnt < 8) cap_byte = {cap_byte[6:0], sda_in};
        if (!scl_prev && scl_in && bitcnt == 8) ack_seen = sda_in;
        if (scl_prev && !scl_in) bitcnt = bitcnt + 1;
        scl_prev = scl_in;
        if (slave_rd) slave_low = (bitcnt >= 0 && bitcnt < 8) ? ~slave_byte[7 - bitcnt] : 1'b0;
        else          slave_low = slave_ack && (bitcnt == 8);
    end

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd1;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(posedge clk);
        @(negedge clk);
        d = readdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Polls STATUS.busy and returns how many cycles it stayed high; optionally
    // pulls scl low between busy-count observations st_at and st_at+st_len.
    task automatic wait_idle(input int st_at, input int st_len, output int n);
        bit seen = 1'b0;
        bit fin  = 1'b0;
        n = 0;
        address = 2'd1;
        for (int i = 0; i < 5000 && !fin; i++) begin
            @(negedge clk);
            if (readdata[0]) begin
                n++;
                seen = 1'b1;
                if (n == st_at)          stretch = 1'b1;
                if (n == st_at + st_len) stretch = 1'b0;
            end else if (seen) begin
                fin = 1'b1;
            end
        end
        stretch = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          n;

        vecs[0]  = '{1'b0, 2'd0, 32'h0,          32'h0};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,          32'h0};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,          32'd124};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,          32'h0};
        vecs[4]  = '{1'b1, 2'd0, 32'h0000_01A5,  32'h0};
        vecs[5]  = '{1'b1, 2'd2, 32'hABCD_1234,  32'h0000_1234};
        vecs[6]  = '{1'b1, 2'd3, 32'hFFFF_FFFF,  32'h0};
        vecs[7]  = '{1'b1, 2'd1, 32'h0000_0020,  32'h0000_0020};
        vecs[8]  = '{1'b1, 2'd1, 32'h0000_00F0,  32'h0000_0020};
        vecs[9]  = '{1'b1, 2'd1, 32'h0000_0000,  32'h0};
        vecs[10] = '{1'b1, 2'd2, 32'h0000_0000,  32'h0};
        vecs[11] = '{1'b1, 2'd2, 32'hFFFF_FFFF,  32'h0000_FFFF};

        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd1;
        writedata  = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_scl_oe", {31'd0, scl_oe}, 32'h0);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata);
            do_read(vecs[i].addr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end
        check("idle_scl_oe", {31'd0, scl_oe}, 32'h0);
        check("idle_irq", {31'd0, irq}, 32'h0);

        // START + WR 0xA5 + STOP at div=4: 44 quarters of 5 cycles.
        do_reset();
        slave_rd  = 1'b0;
        slave_ack = 1'b1;
        arm_req++;
        do_write(2'd2, 32'd4);
        do_write(2'd0, 32'hA5);
        do_write(2'd1, 32'h0B);
        wait_idle(-1, 0, n);
        check("wr_busy_cycles", n, 220);
        check("wr_sda_bits", {24'd0, cap_byte}, 32'hA5);
        check("wr_slave_ack", {31'd0, ack_seen}, 32'h0);
        do_read(2'd1, rd);
        check("wr_status", rd, 32'h04);
        check("wr_irq", {31'd0, irq}, 32'h0);
        check("wr_scl_released", {31'd0, scl_oe}, 32'h0);
        check("wr_sda_released", {31'd0, sda_oe}, 32'h0);

        // Same transfer, slave holds scl low for 50 cycles of bit 3 q1
        // (the first stretched cycle lands in q0 where scl is already low).
        arm_req++;
        cap_byte = 8'h00;
        do_write(2'd1, 32'h0B);
        wait_idle(84, 51, n);
        check("stretch_busy_cycles", n, 270);
        check("stretch_sda_bits", {24'd0, cap_byte}, 32'hA5);
        do_read(2'd1, rd);
        check("stretch_status", rd, 32'h04);

        // WR only at div=0, nobody ACKs: 36 single-cycle quarters, scl parked low.
        do_reset();
        slave_ack = 1'b0;
        arm_req++;
        do_write(2'd2, 32'd0);
        do_write(2'd0, 32'h5A);
        do_write(2'd1, 32'h02);
        wait_idle(-1, 0, n);
        check("nack_busy_cycles", n, 36);
        check("nack_sda_bits", {24'd0, cap_byte}, 32'h5A);
        do_read(2'd1, rd);
        check("nack_status", rd, 32'h06);
        repeat (10) @(negedge clk);
        check("nack_scl_held_low", {31'd0, scl_oe}, 32'h1);
        check("nack_sda_held", {31'd0, sda_oe}, 32'h0);

        // RD + STOP with ACKVAL=1 and IEN at div=1: 40 quarters of 2 cycles.
        do_reset();
        slave_rd   = 1'b1;
        slave_byte = 8'h3C;
        arm_req++;
        do_write(2'd2, 32'd1);
        do_write(2'd1, 32'h3C);
        wait_idle(-1, 0, n);
        check("rd_busy_cycles", n, 80);
        check("rd_ack_released", {31'd0, ack_seen}, 32'h1);
        do_read(2'd0, rd);
        check("rd_data", rd, 32'h3C);
        do_read(2'd1, rd);
        check("rd_status", rd, 32'h24);
        repeat (5) @(negedge clk);
        check("rd_irq_held", {31'd0, irq}, 32'h1);
        do_write(2'd1, 32'h20);
        @(negedge clk);
        check("rd_irq_cleared", {31'd0, irq}, 32'h0);

        // Register writes while busy are dropped; then reset mid-byte aborts.
        do_reset();
        slave_rd  = 1'b0;
        slave_ack = 1'b1;
        arm_req++;
        do_write(2'd2, 32'd4);
        do_write(2'd0, 32'hA5);
        do_write(2'd1, 32'h0B);
        do_write(2'd2, 32'd7);
        do_write(2'd0, 32'hFF);
        do_write(2'd1, 32'h20);
        do_read(2'd2, rd);
        check("busy_div_kept", rd, 32'd4);
        do_read(2'd0, rd);
        check("busy_data_read", rd, 32'h0);
        wait_idle(-1, 0, n);
        check("busy_tx_kept", {24'd0, cap_byte}, 32'hA5);
        do_read(2'd1, rd);
        check("busy_ien_kept", rd, 32'h04);
        do_read(2'd2, rd);
        check("busy_div_after", rd, 32'd4);

        arm_req++;
        do_write(2'd1, 32'h0B);
        repeat (40) @(negedge clk);
        n = 0;
        while (!scl_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_scl_driven", {31'd0, scl_oe}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_scl_oe", {31'd0, scl_oe}, 32'h0);
        check("abort_sda_oe", {31'd0, sda_oe}, 32'h0);
        check("abort_readdata", readdata, 32'h0);
        reset = 1'b0;
        do_read(2'd1, rd);
        check("abort_status", rd, 32'h0);
        do_read(2'd2, rd);
        check("abort_div", rd, 32'd124);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
